// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares one Data_Memory port between
// the datapath (c) and the loader (d); one strobe per request, registered response.
`default_nettype none

module dmem_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_rsp_valid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 8);

    state_t            state;
    logic              last;      // 1: d was granted last
    logic              owner;     // 1: current request belongs to d
    logic              req_err;
    logic              accept;
    logic              grant_d;
    logic              sel_we;
    logic              sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign accept  = ((state == IDLE) || (state == RESP)) && (c_valid || d_valid);
    assign grant_d = d_valid && (!c_valid || !last);
    assign c_ready = accept && !grant_d;
    assign d_ready = accept && grant_d;
    assign busy    = (state != IDLE);

    assign sel_we    = grant_d ? d_we    : c_we;
    assign sel_addr  = grant_d ? d_addr  : c_addr;
    assign sel_wdata = grant_d ? d_wdata : c_wdata;
    assign sel_err   = (sel_addr[2:0] != 3'b000) || (sel_addr >= ADDR_LIMIT);

    // Strobes are launched on the accept edge so they are registered and sit
    // exactly in the ACCESS cycle; the async reset drops them immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            req_err     <= 1'b0;
            MemWrite    <= 1'b0;
            MemRead     <= 1'b0;
            MemAddr     <= '0;
            WriteData   <= '0;
            c_rsp_valid <= 1'b0;
            c_rdata     <= '0;
            c_err       <= 1'b0;
            d_rsp_valid <= 1'b0;
            d_rdata     <= '0;
            d_err       <= 1'b0;
        end else begin
            MemWrite    <= 1'b0;
            MemRead     <= 1'b0;
            c_rsp_valid <= 1'b0;
            c_rdata     <= '0;
            c_err       <= 1'b0;
            d_rsp_valid <= 1'b0;
            d_rdata     <= '0;
            d_err       <= 1'b0;

            if (accept) begin
                last      <= grant_d;
                owner     <= grant_d;
                req_err   <= sel_err;
                MemAddr   <= sel_addr;
                WriteData <= sel_wdata;
                MemWrite  <= sel_we && !sel_err;
                MemRead   <= !sel_we && !sel_err;
            end

            case (state)
                IDLE: begin
                    if (accept) state <= ACCESS;
                end
                ACCESS: begin
                    state       <= RESP;
                    c_rsp_valid <= !owner;
                    c_err       <= !owner && req_err;
                    c_rdata     <= (!owner && MemRead) ? ReadData : '0;
                    d_rsp_valid <= owner;
                    d_err       <= owner && req_err;
                    d_rdata     <= (owner && MemRead) ? ReadData : '0;
                end
                RESP: begin
                    state <= accept ? ACCESS : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// behavioural 128-word memory attached to the shared port.
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        c_valid = 1'b0, c_we = 1'b0;
    logic [63:0] c_addr = '0, c_wdata = '0;
    logic        c_ready, c_rsp_valid, c_err;
    logic [63:0] c_rdata;
    logic        d_valid = 1'b0, d_we = 1'b0;
    logic [63:0] d_addr = '0, d_wdata = '0;
    logic        d_ready, d_rsp_valid, d_err;
    logic [63:0] d_rdata;
    logic        MemWrite, MemRead, busy;
    logic [63:0] MemAddr, WriteData, ReadData;
    logic [63:0] mem [0:127];

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .DEPTH(128)) dut (
        .clk(clk), .rst(rst),
        .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata), .c_err(c_err),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_err(d_err),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemAddr(MemAddr),
        .WriteData(WriteData), .ReadData(ReadData), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ReadData = MemRead ? mem[MemAddr[9:3]] : 64'h0;

    always @(posedge clk) begin
        if (MemWrite) mem[MemAddr[9:3]] <= WriteData;
    end

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({c_ready, d_ready, c_rsp_valid, d_rsp_valid, c_err, d_err, MemWrite, MemRead, busy} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {c_ready, d_ready, c_rsp_valid, d_rsp_valid, c_err, d_err, MemWrite, MemRead, busy});
        end
        checks++;
        if ({c_rdata, d_rdata, MemAddr, WriteData} !== 256'b0) begin
            failures++;
            $display("FAIL reset_data got c_rdata=%h d_rdata=%h addr=%h wdata=%h exp=0", c_rdata, d_rdata, MemAddr, WriteData);
        end
        rst = 1'b1;
    endtask

    task automatic test_single_c;
        logic        v_we   [3] = '{1'b1, 1'b1, 1'b0};
        logic [63:0] v_addr [3] = '{64'd63, 64'd80, 64'd80};
        logic [63:0] v_wd   [3] = '{64'd5, 64'd99, 64'd0};
        logic        v_wr   [3] = '{1'b0, 1'b1, 1'b0};
        logic        v_rd   [3] = '{1'b0, 1'b0, 1'b1};
        logic        v_err  [3] = '{1'b1, 1'b0, 1'b0};
        logic [63:0] v_rdat [3] = '{64'd0, 64'd0, 64'd99};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c_valid = 1'b1; c_we = v_we[i]; c_addr = v_addr[i]; c_wdata = v_wd[i];
            #1;
            checks++;
            if (c_ready !== 1'b1 || d_ready !== 1'b0) begin
                failures++;
                $display("FAIL single_ready[%0d] got c=%b d=%b exp c=1 d=0", i, c_ready, d_ready);
            end
            @(negedge clk);
            c_valid = 1'b0;
            checks++;
            if (MemWrite !== v_wr[i] || MemRead !== v_rd[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_strobe[%0d] got wr=%b rd=%b busy=%b exp wr=%b rd=%b busy=1", i, MemWrite, MemRead, busy, v_wr[i], v_rd[i]);
            end
            if (v_wr[i] || v_rd[i]) begin
                checks++;
                if (MemAddr !== v_addr[i]) begin
                    failures++;
                    $display("FAIL single_addr[%0d] got=%0d exp=%0d", i, MemAddr, v_addr[i]);
                end
            end
            @(negedge clk);
            checks++;
            if (c_rsp_valid !== 1'b1 || c_err !== v_err[i] || c_rdata !== v_rdat[i] || d_rsp_valid !== 1'b0 || MemWrite !== 1'b0) begin
                failures++;
                $display("FAIL single_rsp[%0d] got v=%b err=%b rdata=%0d dv=%b wr=%b exp v=1 err=%b rdata=%0d dv=0 wr=0",
                         i, c_rsp_valid, c_err, c_rdata, d_rsp_valid, MemWrite, v_err[i], v_rdat[i]);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || c_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_idle[%0d] got busy=%b rsp=%b exp 0 0", i, busy, c_rsp_valid);
            end
        end
    endtask

    task automatic test_simultaneous;
        mem[2] = 64'hAAAA; mem[3] = 64'hBBBB;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        c_valid = 1'b1; c_we = 1'b0; c_addr = 64'd16;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 64'd24;
        #1;
        checks++;
        if (c_ready !== 1'b1 || d_ready !== 1'b0) begin
            failures++;
            $display("FAIL simul_first got c=%b d=%b exp c=1 d=0", c_ready, d_ready);
        end
        @(negedge clk);
        c_valid = 1'b0;
        #1;
        checks++;
        if (MemRead !== 1'b1 || MemAddr !== 64'd16 || d_ready !== 1'b0) begin
            failures++;
            $display("FAIL simul_c_access got rd=%b addr=%0d dready=%b exp 1 16 0", MemRead, MemAddr, d_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (c_rsp_valid !== 1'b1 || c_rdata !== 64'hAAAA || d_ready !== 1'b1 || MemRead !== 1'b0) begin
            failures++;
            $display("FAIL simul_c_rsp got v=%b rdata=%h dready=%b rd=%b exp 1 aaaa 1 0", c_rsp_valid, c_rdata, d_ready, MemRead);
        end
        @(negedge clk);
        d_valid = 1'b0;
        checks++;
        if (MemRead !== 1'b1 || MemAddr !== 64'd24 || c_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_d_access got rd=%b addr=%0d crsp=%b exp 1 24 0", MemRead, MemAddr, c_rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rdata !== 64'hBBBB || c_rsp_valid !== 1'b0 || c_rdata !== 64'h0) begin
            failures++;
            $display("FAIL simul_d_rsp got v=%b rdata=%h cv=%b crdata=%h exp 1 bbbb 0 0", d_rsp_valid, d_rdata, c_rsp_valid, c_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int   c_acc = 0, d_acc = 0, c_rsp = 0, d_rsp = 0;
        int   strobes = 0, last_strobe = -1;
        logic prev_g = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 64'h1000 + 64'(i);
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (c_rsp_valid) begin
                checks++;
                if (c_rdata !== 64'h1000 + 64'(c_rsp)) begin
                    failures++;
                    $display("FAIL stream_c_rdata[%0d] got=%h exp=%h", c_rsp, c_rdata, 64'h1000 + 64'(c_rsp));
                end
                c_rsp++;
            end
            if (d_rsp_valid) begin
                checks++;
                if (d_rdata !== 64'h1008 + 64'(d_rsp)) begin
                    failures++;
                    $display("FAIL stream_d_rdata[%0d] got=%h exp=%h", d_rsp, d_rdata, 64'h1008 + 64'(d_rsp));
                end
                d_rsp++;
            end
            if (MemRead) begin
                if (last_strobe >= 0) begin
                    checks++;
                    if (cyc - last_strobe != 2) begin
                        failures++;
                        $display("FAIL stream_gap got=%0d exp=2", cyc - last_strobe);
                    end
                end
                last_strobe = cyc;
                strobes++;
            end
            if (c_rsp == 8 && d_rsp == 8) break;
            c_valid = (c_acc < 8); c_we = 1'b0; c_addr = 64'(c_acc * 8);
            d_valid = (d_acc < 8); d_we = 1'b0; d_addr = 64'((8 + d_acc) * 8);
            #1;
            if (c_ready || d_ready) begin
                checks++;
                if ((c_ready && d_ready) || d_ready === prev_g) begin
                    failures++;
                    $display("FAIL stream_alternate got c=%b d=%b prev_d=%b", c_ready, d_ready, prev_g);
                end
                prev_g = d_ready;
            end
            if (c_ready) c_acc++;
            if (d_ready) d_acc++;
        end
        c_valid = 1'b0; d_valid = 1'b0;
        checks++;
        if (c_rsp != 8 || d_rsp != 8 || strobes != 16) begin
            failures++;
            $display("FAIL stream_counts got c=%0d d=%0d strobes=%0d exp 8 8 16", c_rsp, d_rsp, strobes);
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range;
        logic [63:0] v_addr [2] = '{64'd1024, 64'd1016};
        logic        v_err  [2] = '{1'b1, 1'b0};
        logic [63:0] v_rdat [2] = '{64'd0, 64'h5A5A};
        mem[127] = 64'h5A5A;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d_valid = 1'b1; d_we = 1'b0; d_addr = v_addr[i];
            #1;
            checks++;
            if (d_ready !== 1'b1) begin
                failures++;
                $display("FAIL oor_ready[%0d] got=%b exp=1", i, d_ready);
            end
            @(negedge clk);
            d_valid = 1'b0;
            checks++;
            if (MemRead !== !v_err[i] || MemWrite !== 1'b0) begin
                failures++;
                $display("FAIL oor_strobe[%0d] got rd=%b wr=%b exp rd=%b wr=0", i, MemRead, MemWrite, !v_err[i]);
            end
            @(negedge clk);
            checks++;
            if (d_rsp_valid !== 1'b1 || d_err !== v_err[i] || d_rdata !== v_rdat[i]) begin
                failures++;
                $display("FAIL oor_rsp[%0d] got v=%b err=%b rdata=%h exp 1 %b %h", i, d_rsp_valid, d_err, d_rdata, v_err[i], v_rdat[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        c_valid = 1'b1; c_we = 1'b0; c_addr = 64'd8;
        @(negedge clk);
        c_valid = 1'b0;
        checks++;
        if (MemRead !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_strobe got=%b exp=1", MemRead);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (MemRead !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_drop got rd=%b busy=%b exp 0 0", MemRead, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (c_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_norsp[%0d] got c=%b d=%b exp 0 0", i, c_rsp_valid, d_rsp_valid);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        c_valid = 1'b1; c_we = 1'b0; c_addr = 64'd8;
        #1;
        checks++;
        if (c_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ready got=%b exp=1", c_ready);
        end
        @(negedge clk);
        c_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (c_rsp_valid !== 1'b1 || c_rdata !== 64'h1001 || c_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after got v=%b rdata=%h err=%b exp 1 1001 0", c_rsp_valid, c_rdata, c_err);
        end
    endtask

    task automatic test_drop_valid;
        @(negedge clk);
        c_valid = 1'b1; c_we = 1'b1; c_addr = 64'd40; c_wdata = 64'hDEAD;
        d_valid = 1'b1; d_we = 1'b1; d_addr = 64'd48; d_wdata = 64'hBEEF;
        #1;
        checks++;
        if (d_ready !== 1'b1 || c_ready !== 1'b0) begin
            failures++;
            $display("FAIL drop_grant got c=%b d=%b exp c=0 d=1", c_ready, d_ready);
        end
        @(negedge clk);
        c_valid = 1'b0; d_valid = 1'b0;
        checks++;
        if (MemWrite !== 1'b1 || MemAddr !== 64'd48 || WriteData !== 64'hBEEF) begin
            failures++;
            $display("FAIL drop_access got wr=%b addr=%0d wdata=%h exp 1 48 beef", MemWrite, MemAddr, WriteData);
        end
        @(negedge clk);
        checks++;
        if (d_rsp_valid !== 1'b1 || c_rsp_valid !== 1'b0 || c_ready !== 1'b0) begin
            failures++;
            $display("FAIL drop_rsp got d=%b c=%b cready=%b exp 1 0 0", d_rsp_valid, c_rsp_valid, c_ready);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || c_rsp_valid !== 1'b0 || mem[6] !== 64'hBEEF || mem[5] === 64'hDEAD) begin
            failures++;
            $display("FAIL drop_final got busy=%b crsp=%b mem6=%h mem5=%h exp 0 0 beef !dead", busy, c_rsp_valid, mem[6], mem[5]);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        test_single_c();
        test_simultaneous();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_drop_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
